fifo_stream_reader: RTL

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader_if.sv | 53 +++++
 rtl/fifo_stream_reader.sv | 134 +++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader_if.sv
// Stream reader bus: FIFO read side plus valid/ready output stream.
// FIFO_READER_STATS_EN adds the words_read statistics counter.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_rd_en;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;
`ifdef FIFO_READER_STATS_EN
    logic [15:0]           words_read;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        input  out_ready,
        output fifo_rd_en,
        output out_valid,
        output out_data,
        output words_read
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        output out_ready,
        input  fifo_rd_en,
        input  out_valid,
        input  out_data,
        input  words_read
    );
`else
    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        input  out_ready,
        output fifo_rd_en,
        output out_valid,
        output out_data
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        output out_ready,
        input  fifo_rd_en,
        input  out_valid,
        input  out_data
    );
`endif
endinterface

// File: rtl/fifo_stream_reader.sv
// Turns a registered-read synchronous FIFO into a valid/ready stream
// through a 2-entry skid buffer. FIFO_READER_STATS_EN adds words_read.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    fifo_stream_reader_if.master    bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t                  r_occ;
    occ_t                  w_occ_nxt;
    logic                  r_inflight;
    logic                  r_head;
    logic [DATA_WIDTH-1:0] r_buf [2];
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;

    logic                  w_pop;
    logic                  w_cap;
    logic [2:0]            w_level;
    logic                  w_rd_en;
    logic                  w_wr_idx;
    logic                  w_head_nxt;
    logic [DATA_WIDTH-1:0] w_data_nxt;

    assign w_pop      = r_valid & bus.out_ready;
    assign w_cap      = r_inflight;
    assign w_level    = {1'b0, r_occ} + {2'b00, r_inflight};
    assign w_wr_idx   = r_head ^ (r_occ == ONE);
    assign w_head_nxt = r_head ^ w_pop;

    // Read request: keep buffered + in-flight words at most two.
    always_comb begin
        w_rd_en = 1'b0;
        if (!rst && !bus.fifo_empty) begin
            if (w_level <= 3'd1) begin
                w_rd_en = 1'b1;
            end else if (w_level == 3'd2 && w_pop) begin
                w_rd_en = 1'b1;
            end
        end
    end

    // Occupancy next state from capture and pop.
    always_comb begin
        w_occ_nxt = r_occ;
        unique case (r_occ)
            EMPTY: begin
                if (w_cap) begin
                    w_occ_nxt = ONE;
                end
            end
            ONE: begin
                if (w_cap && !w_pop) begin
                    w_occ_nxt = TWO;
                end else if (!w_cap && w_pop) begin
                    w_occ_nxt = EMPTY;
                end
            end
            TWO: begin
                if (w_pop) begin
                    w_occ_nxt = ONE;
                end
            end
            default: w_occ_nxt = EMPTY;
        endcase
    end

    // Head word after this edge; a capture may land straight in the head.
    always_comb begin
        w_data_nxt = r_buf[w_head_nxt];
        if (w_cap && (w_wr_idx == w_head_nxt)) begin
            w_data_nxt = bus.fifo_rd_data;
        end
    end

    // Occupancy state and in-flight read flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ      <= EMPTY;
            r_inflight <= 1'b0;
        end else begin
            r_occ      <= w_occ_nxt;
            r_inflight <= w_rd_en;
        end
    end

    // Buffer storage, head pointer and registered stream outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
            r_head   <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= '0;
        end else begin
            if (w_cap) begin
                r_buf[w_wr_idx] <= bus.fifo_rd_data;
            end
            r_head  <= w_head_nxt;
            r_valid <= (w_occ_nxt != EMPTY);
            if (w_occ_nxt != EMPTY) begin
                r_data <= w_data_nxt;
            end
        end
    end

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.out_valid  = r_valid;
    assign bus.out_data   = r_data;

`ifdef FIFO_READER_STATS_EN
    logic [15:0] r_words_read;

    // Count accepted stream words, wrapping at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_words_read <= 16'h0000;
        end else if (w_pop) begin
            r_words_read <= r_words_read + 16'h0001;
        end
    end

    assign bus.words_read = r_words_read;
`endif

endmodule
